pwm_throttle_ramp: RTL
======================

// Module: pwm_throttle_ramp
// PURPOSE
//  Upstream stage of pwm_generator: turns flight-controller throttle commands into the duty
//  value (0..DUTY_MAX percent) that drives the motor PWM. Enforces an arm sequence and clamps
//  commands. Slew-limits duty changes so the ESC never sees a step larger than STEP per tick.
//  duty_out connects directly to the generator's duty/offset input.
// PARAMETERS
//  DUTY_W     7    width of cmd_duty and duty_out
//  DUTY_MAX   100  largest legal duty; commands above it are clamped
//  STEP       2    maximum duty change per tick (1..DUTY_MAX)
//  TICK_DIV   532  clk cycles per tick; matches the generator's 1/100-period step
//  ARM_TICKS  50   ticks duty is held at 0 in ARMING before commands are accepted
// PORTS
//  clk         in   1       system clock
//  rst_n       in   1       async active-low reset
//  arm         in   1       level; 1 = request armed, 0 = disarm immediately
//  cmd_valid   in   1       throttle command valid
//  cmd_ready   out  1       block accepts a command (ARMED state only)
//  cmd_duty    in   DUTY_W  requested duty, percent
//  duty_out    out  DUTY_W  registered duty to pwm_generator
//  armed       out  1       1 in ARMED state
//  at_target   out  1       1 when duty_out == target
//  clamped     out  1       one-cycle pulse: accepted cmd_duty > DUTY_MAX
// BEHAVIOUR
//  Reset (async assert, sync release): state=DISARMED, duty_out=0, target=0, tick counter=0,
//   armed=0, cmd_ready=0, clamped=0, at_target=1.
//  Tick: free-running counter 0..TICK_DIV-1. tick=1 on the cycle the count equals TICK_DIV-1,
//   then the counter wraps to 0. Counts in every state.
//  States:
//   DISARMED: duty_out=0, target=0. arm=1 -> ARMING with arm-tick count cleared.
//   ARMING: duty_out held at 0. Counts ticks; on the ARM_TICKS-th tick -> ARMED.
//    arm=0 -> DISARMED.
//   ARMED: cmd_ready=1, armed=1. arm=0 -> DISARMED next cycle. In that same cycle
//    duty_out=0 and target=0 (no ramp-down; disarm is an emergency cut).
//  Handshake: a transfer occurs when cmd_valid & cmd_ready on a clk edge.
//   target <= min(cmd_duty, DUTY_MAX). clamped pulses for 1 cycle if cmd_duty > DUTY_MAX.
//   Commands presented outside ARMED are not accepted and are not queued.
//  Ramp (ARMED, on tick only):
//   duty<target: duty <= min(duty+STEP, target)
//   duty>target: duty <= max(duty-STEP, target)
//   Computed in DUTY_W+1 bits; no overflow above DUTY_MAX and no underflow below 0.
//  Simultaneous transfer and tick: the ramp uses the old target. The new target applies
//   from the next tick.
//  Simultaneous arm fall and transfer/tick: disarm wins; the command is dropped and duty_out=0.
//  Latency: an accepted command first changes duty_out on the next tick. Full slew from 0 to
//   N takes ceil(N/STEP) ticks.
//  at_target = (duty_out == target), registered-derived, no extra latency.
//  Reset mid-ramp: all state returns to reset values immediately (async).
// TESTING  (bench uses TICK_DIV=4, ARM_TICKS=3, STEP=2, DUTY_MAX=100)
//  Reset, arm=1 held -> cmd_ready=0 for 12 cycles (3 ticks), then armed=1, cmd_ready=1;
//   duty_out=0 throughout.
//  Armed, send cmd_duty=10 -> duty_out 2,4,6,8,10 on successive ticks; at_target=1 after the 5th.
//  Armed at duty 10, send cmd_duty=5 -> duty_out 8,6,5 (final step clamped to target).
//  Send cmd_duty=127 -> clamped pulses once, target=100, duty_out saturates at 100, never >100.
//  Mid-ramp at duty 40, drop arm -> next cycle duty_out=0, armed=0, cmd_ready=0.
//   Re-arm requires a full 3-tick ARMING.
//  Transfer on a tick cycle (old target 20, duty 10, new 4) -> that tick gives duty 12,
//   then 10,8,6,4. Assert rst_n=0 mid-ramp -> all outputs reset without a clk edge.

Source files
------------

// File: rtl/pwm_throttle_ramp.sv
// pwm_throttle_ramp
//   Converts flight-controller throttle commands into the duty value (0..DUTY_MAX percent)
//   that feeds pwm_generator. It runs an arm sequence, clamps commands to DUTY_MAX, and limits
//   the slew of duty_out to STEP per tick.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   arm        level: 1 requests armed, 0 disarms immediately
//   cmd_valid  throttle command valid
//   cmd_ready  command accepted this cycle if valid (ARMED only)
//   cmd_duty   requested duty, percent
//   duty_out   registered duty to pwm_generator
//   armed      high in ARMED
//   at_target  duty_out equals the current target
//   clamped    one-cycle pulse after accepting a command above DUTY_MAX
module pwm_throttle_ramp #(
    parameter int unsigned DUTY_W    = 7,
    parameter int unsigned DUTY_MAX  = 100,
    parameter int unsigned STEP      = 2,
    parameter int unsigned TICK_DIV  = 532,
    parameter int unsigned ARM_TICKS = 50
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_duty,
    output logic [DUTY_W-1:0] duty_out,
    output logic              armed,
    output logic              at_target,
    output logic              clamped
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned ArmW = (ARM_TICKS > 1) ? $clog2(ARM_TICKS + 1) : 1;

    localparam logic [CntW-1:0]   TickLast = CntW'(TICK_DIV - 1);
    localparam logic [ArmW-1:0]   ArmLast  = ArmW'(ARM_TICKS - 1);
    localparam logic [DUTY_W-1:0] DutyMax  = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] StepNar  = DUTY_W'(STEP);
    localparam logic [DUTY_W:0]   StepExt  = (DUTY_W + 1)'(STEP);

    typedef enum logic [1:0] {
        StDisarmed = 2'd0,
        StArming   = 2'd1,
        StArmed    = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ArmW-1:0]   arm_cnt_q, arm_cnt_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] target_q, target_d;
    logic              clamped_q, clamped_d;

    logic              tick;
    logic [DUTY_W:0]   duty_ext, tgt_ext, up_sum, down_floor;
    logic [DUTY_W-1:0] ramp_val;

    // Free-running tick divider, independent of state.
    assign tick  = (cnt_q == TickLast);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    // Slew step toward target_q, computed one bit wider so neither direction can wrap.
    always_comb begin
        duty_ext   = {1'b0, duty_q};
        tgt_ext    = {1'b0, target_q};
        up_sum     = duty_ext + StepExt;
        down_floor = tgt_ext + StepExt;
        ramp_val   = duty_q;
        if (duty_q < target_q) begin
            ramp_val = (up_sum >= tgt_ext) ? target_q : up_sum[DUTY_W-1:0];
        end else if (duty_q > target_q) begin
            // Only subtract when the result stays at or above target (hence >= STEP).
            ramp_val = (duty_ext >= down_floor) ? (duty_q - StepNar) : target_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        duty_d    = duty_q;
        target_d  = target_q;
        clamped_d = 1'b0;
        unique case (state_q)
            StDisarmed: begin
                duty_d   = '0;
                target_d = '0;
                if (arm) begin
                    state_d   = StArming;
                    arm_cnt_d = '0;
                end
            end
            StArming: begin
                duty_d   = '0;
                target_d = '0;
                if (!arm) begin
                    state_d = StDisarmed;
                end else if (tick) begin
                    if (arm_cnt_q == ArmLast) begin
                        state_d = StArmed;
                    end else begin
                        arm_cnt_d = arm_cnt_q + 1'b1;
                    end
                end
            end
            StArmed: begin
                if (!arm) begin
                    // Emergency cut: no ramp-down, any concurrent command is dropped.
                    state_d  = StDisarmed;
                    duty_d   = '0;
                    target_d = '0;
                end else begin
                    // Ramp reads target_q, so a same-cycle transfer only affects later ticks.
                    if (tick) begin
                        duty_d = ramp_val;
                    end
                    if (cmd_valid) begin
                        target_d  = (cmd_duty > DutyMax) ? DutyMax : cmd_duty;
                        clamped_d = (cmd_duty > DutyMax);
                    end
                end
            end
            default: begin
                state_d  = StDisarmed;
                duty_d   = '0;
                target_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StDisarmed;
            cnt_q     <= '0;
            arm_cnt_q <= '0;
            duty_q    <= '0;
            target_q  <= '0;
            clamped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            arm_cnt_q <= arm_cnt_d;
            duty_q    <= duty_d;
            target_q  <= target_d;
            clamped_q <= clamped_d;
        end
    end

    assign cmd_ready = (state_q == StArmed);
    assign armed     = (state_q == StArmed);
    assign duty_out  = duty_q;
    assign at_target = (duty_q == target_q);
    assign clamped   = clamped_q;

endmodule
